// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: game state machine driving start/life/restart load strobes, lives, invulnerability and saturating score.
module game_flow_ctrl #(
  parameter int LIVES = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int SCORE_W = 10
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               start_key,
  input  logic               pause_key,
  input  logic               hit,
  output logic               start_clr,
  output logic [LIVES-1:0]   life_clr,
  output logic               game_rst,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic               playing,
  output logic               invuln,
  output logic               paused,
  output logic               game_over
);
  typedef enum logic [2:0] {IDLE, PLAY, HIT, PAUSE, OVER} state_t;
  state_t     r_state;
  logic       r_start_prev, r_pause_prev;
  logic [7:0] r_cnt;
  logic       w_start_ev, w_pause_ev, w_score_inc;
  assign w_start_ev  = start_key & ~r_start_prev;
  assign w_pause_ev  = pause_key & ~r_pause_prev;
  assign w_score_inc = frame_tick & (r_state == PLAY || r_state == HIT) & ~&score;
  assign playing     = r_state == PLAY || r_state == HIT;
  assign invuln      = r_state == HIT;
  assign paused      = r_state == PAUSE;
  assign game_over   = r_state == OVER;
  // Previous-key registers reset high so a key held through reset is not an event.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_start_prev <= 1'b1;
      r_pause_prev <= 1'b1;
      r_cnt        <= '0;
      lives        <= 3'(LIVES);
      score        <= '0;
      start_clr    <= 1'b0;
      life_clr     <= '0;
      game_rst     <= 1'b0;
    end else begin
      r_start_prev <= start_key;
      r_pause_prev <= pause_key;
      start_clr    <= 1'b0;
      life_clr     <= '0;
      game_rst     <= 1'b0;
      if (w_score_inc) score <= score + 1'b1;
      case (r_state)
        IDLE: if (w_start_ev) begin
          r_state   <= PLAY;
          start_clr <= 1'b1;
          score     <= '0;
          lives     <= 3'(LIVES);
        end
        PLAY: if (hit) begin
          life_clr <= LIVES'(1) << (lives - 3'd1);
          lives    <= lives - 3'd1;
          r_state  <= lives == 3'd1 ? OVER : HIT;
          r_cnt    <= 8'(INVULN_FRAMES);
        end else if (w_pause_ev) r_state <= PAUSE;
        HIT: if (frame_tick) begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) r_state <= PLAY;
        end
        PAUSE: if (w_pause_ev) r_state <= PLAY;
        OVER: if (w_start_ev) begin
          r_state  <= IDLE;
          game_rst <= 1'b1;
          lives    <= 3'(LIVES);
          score    <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: vector table, directed corner sequences and random stimulus against a phase/window reference model.
module tb_game_flow_ctrl;
  localparam int L = 3, INV = 60, SW = 10, SMAX = (1 << SW) - 1;
  logic Clk = 0, Reset = 1, frame_tick = 0, start_key = 0, pause_key = 0, hit = 0;
  logic start_clr, game_rst, playing, invuln, paused, game_over;
  logic [L-1:0] life_clr;
  logic [2:0] lives;
  logic [SW-1:0] score;
  int cmp = 0, err = 0;
  int m_phase, m_lives, m_score, m_win, e_sc, e_lc, e_gr;
  bit m_sp, m_pp;
  typedef struct {
    logic st, pa, hi, tk, sc;
    logic [2:0] lc;
    logic gr;
    int lv, sco;
    logic ply, inv, pau, ovr;
  } vec_t;
  vec_t tv[12];

  game_flow_ctrl #(.LIVES(L), .INVULN_FRAMES(INV), .SCORE_W(SW)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start_key(start_key),
    .pause_key(pause_key), .hit(hit), .start_clr(start_clr), .life_clr(life_clr),
    .game_rst(game_rst), .lives(lives), .score(score), .playing(playing),
    .invuln(invuln), .paused(paused), .game_over(game_over));

  always #5 Clk = ~Clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    cmp++;
    if (a !== e) begin
      err++;
      $display("FAIL %s act=%0d exp=%0d @%0t", n, a, e, $time);
    end
  endtask

  task automatic check_exp(input string t, input int sc, lc, gr, lv, sco, ply, inv, pau, ovr);
    chk({t, ".start_clr"}, 32'(start_clr), 32'(sc));
    chk({t, ".life_clr"}, 32'(life_clr), 32'(lc));
    chk({t, ".game_rst"}, 32'(game_rst), 32'(gr));
    chk({t, ".lives"}, 32'(lives), 32'(lv));
    chk({t, ".score"}, 32'(score), 32'(sco));
    chk({t, ".playing"}, 32'(playing), 32'(ply));
    chk({t, ".invuln"}, 32'(invuln), 32'(inv));
    chk({t, ".paused"}, 32'(paused), 32'(pau));
    chk({t, ".game_over"}, 32'(game_over), 32'(ovr));
  endtask

  // Phases: 0 idle, 1 in game (invulnerable while m_win > 0), 2 paused, 3 over.
  task automatic model_reset();
    m_phase = 0; m_lives = L; m_score = 0; m_win = 0;
    m_sp = 1; m_pp = 1; e_sc = 0; e_lc = 0; e_gr = 0;
  endtask

  task automatic model_step(input bit st, pa, hi, tk);
    bit sev, pev;
    sev = st && !m_sp; pev = pa && !m_pp; m_sp = st; m_pp = pa;
    e_sc = 0; e_lc = 0; e_gr = 0;
    if (m_phase == 1 && tk && m_score < SMAX) m_score++;
    if (m_phase == 0 && sev) begin
      m_phase = 1; m_win = 0; m_score = 0; m_lives = L; e_sc = 1;
    end else if (m_phase == 1 && m_win > 0) begin
      if (tk) m_win--;
    end else if (m_phase == 1 && hi) begin
      e_lc = 1 << (m_lives - 1); m_lives--;
      if (m_lives == 0) m_phase = 3; else m_win = INV;
    end else if (m_phase == 1 && pev) m_phase = 2;
    else if (m_phase == 2 && pev) m_phase = 1;
    else if (m_phase == 3 && sev) begin
      m_phase = 0; e_gr = 1; m_lives = L; m_score = 0;
    end
  endtask

  task automatic check_model(input string t);
    check_exp(t, e_sc, e_lc, e_gr, m_lives, m_score, int'(m_phase == 1), int'(m_phase == 1 && m_win > 0),
              int'(m_phase == 2), int'(m_phase == 3));
  endtask

  task automatic step(input bit st, pa, hi, tk, input string t);
    start_key = st; pause_key = pa; hit = hi; frame_tick = tk;
    @(posedge Clk); #1;
    model_step(st, pa, hi, tk);
    check_model(t);
  endtask

  initial begin
    tv[0]  = '{0,0,0,0, 0,0,0,3,0, 0,0,0,0};
    tv[1]  = '{1,0,0,0, 1,0,0,3,0, 1,0,0,0};
    tv[2]  = '{0,0,0,1, 0,0,0,3,1, 1,0,0,0};
    tv[3]  = '{0,0,0,1, 0,0,0,3,2, 1,0,0,0};
    tv[4]  = '{0,1,0,0, 0,0,0,3,2, 0,0,1,0};
    tv[5]  = '{0,0,1,1, 0,0,0,3,2, 0,0,1,0};
    tv[6]  = '{0,1,0,0, 0,0,0,3,2, 1,0,0,0};
    tv[7]  = '{0,0,1,1, 0,4,0,2,3, 1,1,0,0};
    tv[8]  = '{0,0,1,0, 0,0,0,2,3, 1,1,0,0};
    tv[9]  = '{1,0,0,0, 0,0,0,2,3, 1,1,0,0};
    tv[10] = '{0,1,0,0, 0,0,0,2,3, 1,1,0,0};
    tv[11] = '{0,0,0,0, 0,0,0,2,3, 1,1,0,0};
    model_reset();
    repeat (2) @(posedge Clk);
    #1 check_model("reset");
    Reset = 0;
    for (int i = 0; i < 12; i++) begin
      step(tv[i].st, tv[i].pa, tv[i].hi, tv[i].tk, "tv_model");
      check_exp($sformatf("tv%0d", i), tv[i].sc, tv[i].lc, tv[i].gr, tv[i].lv, tv[i].sco,
                tv[i].ply, tv[i].inv, tv[i].pau, tv[i].ovr);
    end
    for (int i = 0; i < INV - 1; i++) step(0, 0, 0, 1, "window");
    chk("window_last_tick_pending", 32'(invuln), 1);
    step(0, 0, 1, 1, "window_end");
    chk("window_end_invuln", 32'(invuln), 0);
    chk("hit_on_exit_ignored", 32'(lives), 2);
    step(0, 0, 1, 0, "hit2");
    chk("hit2_life_clr", 32'(life_clr), 3'b010);
    for (int i = 0; i < INV; i++) step(0, 0, 0, 1, "window2");
    step(0, 0, 1, 0, "hit3");
    chk("hit3_life_clr", 32'(life_clr), 3'b001);
    chk("hit3_over", 32'({lives, game_over}), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, "over_hold");
    chk("over_score_hold", 32'(score), 123);
    step(1, 0, 0, 0, "over_start");
    chk("game_rst", 32'({game_rst, playing, game_over}), 3'b100);
    step(0, 0, 0, 0, "game_rst_one_cycle");
    step(1, 0, 0, 0, "restart");
    for (int i = 0; i < SMAX + 2; i++) step(0, 0, 0, 1, "sat");
    chk("score_saturated", 32'(score), SMAX);
    step(0, 1, 1, 0, "hit_pause");
    chk("hit_beats_pause", 32'({paused, invuln, lives}), {2'b01, 3'd2});
    for (int i = 0; i < 30; i++) step(0, 0, 0, 1, "to30");
    start_key = 1;
    #3 Reset = 1;
    #1 model_reset();
    check_model("async_reset");
    repeat (2) @(posedge Clk);
    #1 Reset = 0;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, "held_start");
    chk("held_start_no_event", 32'(playing), 0);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(9) == 0 ? !start_key : start_key, $urandom_range(9) == 0 ? !pause_key : pause_key,
           $urandom_range(15) == 0, $urandom_range(3) == 0, "rand");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
